// File: rtl/edge_tally.sv
// edge_tally
// Counts per-node degree over a window of graph edges. Edges are accepted
// while collecting. The window closes when WINSIZE edges have been accepted
// or when win_end is pulsed. The per-node degree table is then frozen and
// published for a reader until rd_done. A one-cycle clear follows, and then
// collection restarts.
//
// Ports
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   edge_vld     edge offer valid
//   edge_src     source node ID of the offered edge
//   edge_dst     destination node ID of the offered edge
//   edge_rdy     edge can be accepted this cycle (collecting only)
//   win_end      pulse: close the window early
//   data_rdy     window closed; degree table stable and readable
//   rd_addr      node ID for a table read
//   num_edges    registered degree of node rd_addr (1-cycle latency)
//   rd_done      pulse: reader finished, release the table
//   edges_total  accepted edge count of the closed window
//   err_oor      sticky: an accepted edge had an endpoint >= POPSIZE
module edge_tally #(
   parameter int POPSIZE = 100,
   parameter int WINSIZE = 200,
   localparam int CW = $clog2(WINSIZE) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          edge_vld,
   input  logic [7:0]    edge_src,
   input  logic [7:0]    edge_dst,
   output logic          edge_rdy,
   input  logic          win_end,
   output logic          data_rdy,
   input  logic [7:0]    rd_addr,
   output logic [CW-1:0] num_edges,
   input  logic          rd_done,
   output logic [CW-1:0] edges_total,
   output logic          err_oor
);

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_PUBLISH = 2'd1,
      ST_CLEAR   = 2'd2
   } state_t;

   state_t                   state_r, state_s;
   logic                     accept_s, win_full_s, src_oor_s, dst_oor_s;
   logic [CW-1:0]            win_cnt_r, win_cnt_s, win_inc_s;
   logic [CW-1:0]            edges_total_r, edges_total_s;
   logic [CW-1:0]            num_edges_r, rd_val_s;
   logic [POPSIZE-1:0][CW-1:0] cnt_r, cnt_s;
   logic                     edge_rdy_r, data_rdy_r, err_oor_r;

   // Saturating add of a 0..2 increment; a count never wraps past all-ones.
   function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                             input logic [1:0]    b);
      logic [CW:0] sum;
      sum = {1'b0, a} + {{(CW-1){1'b0}}, b};
      return sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
   endfunction

   // Accept decode, window-full detect and endpoint range checks.
   always_comb begin
      accept_s   = edge_vld && (state_r == ST_COLLECT);
      win_inc_s  = win_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      win_full_s = accept_s && (win_inc_s == CW'(WINSIZE));
      src_oor_s  = (int'(edge_src) >= POPSIZE);
      dst_oor_s  = (int'(edge_dst) >= POPSIZE);
   end

   // Next-state logic for the collect / publish / clear cycle.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_COLLECT: begin
            // A same-cycle accept is still counted; see the counter logic.
            if (win_full_s || win_end) state_s = ST_PUBLISH;
            else                       state_s = ST_COLLECT;
         end
         ST_PUBLISH: begin
            if (rd_done) state_s = ST_CLEAR;
            else         state_s = ST_PUBLISH;
         end
         ST_CLEAR: state_s = ST_COLLECT;
         default:  state_s = ST_COLLECT;
      endcase
   end

   // Window counter and the edge total captured when the window closes.
   always_comb begin
      win_cnt_s     = win_cnt_r;
      edges_total_s = edges_total_r;
      case (state_r)
         ST_COLLECT: begin
            if (accept_s) win_cnt_s = win_inc_s;
            else          win_cnt_s = win_cnt_r;
            if (state_s == ST_PUBLISH) edges_total_s = win_cnt_s;
            else                       edges_total_s = edges_total_r;
         end
         ST_CLEAR: begin
            win_cnt_s     = {CW{1'b0}};
            edges_total_s = {CW{1'b0}};
         end
         default: begin
            win_cnt_s     = win_cnt_r;
            edges_total_s = edges_total_r;
         end
      endcase
   end

   // Degree table update. An out-of-range endpoint matches no node, so it
   // is simply not counted. A self-loop hits the same node twice (+2).
   always_comb begin
      cnt_s = cnt_r;
      case (state_r)
         ST_COLLECT: begin
            for (int i = 0; i < POPSIZE; i++) begin
               cnt_s[i] = sat_add(cnt_r[i],
                  {1'b0, accept_s && (int'(edge_src) == i)} +
                  {1'b0, accept_s && (int'(edge_dst) == i)});
            end
         end
         ST_CLEAR: cnt_s = {(POPSIZE*CW){1'b0}};
         default:  cnt_s = cnt_r;
      endcase
   end

   // Table read mux; addresses beyond the population return zero.
   always_comb begin
      rd_val_s = {CW{1'b0}};
      for (int i = 0; i < POPSIZE; i++) begin
         rd_val_s = (int'(rd_addr) == i) ? cnt_r[i] : rd_val_s;
      end
   end

   // State, table and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_COLLECT;
         cnt_r         <= {(POPSIZE*CW){1'b0}};
         win_cnt_r     <= {CW{1'b0}};
         edges_total_r <= {CW{1'b0}};
         num_edges_r   <= {CW{1'b0}};
         edge_rdy_r    <= 1'b1;
         data_rdy_r    <= 1'b0;
         err_oor_r     <= 1'b0;
      end else begin
         state_r       <= state_s;
         cnt_r         <= cnt_s;
         win_cnt_r     <= win_cnt_s;
         edges_total_r <= edges_total_s;
         num_edges_r   <= rd_val_s;
         edge_rdy_r    <= (state_s == ST_COLLECT);
         data_rdy_r    <= (state_s == ST_PUBLISH);
         err_oor_r     <= err_oor_r | (accept_s & (src_oor_s | dst_oor_s));
      end
   end

   assign edge_rdy    = edge_rdy_r;
   assign data_rdy    = data_rdy_r;
   assign num_edges   = num_edges_r;
   assign edges_total = edges_total_r;
   assign err_oor     = err_oor_r;

endmodule

// File: tb/tb_edge_tally.sv
// Self-checking bench for edge_tally. A behavioural degree model pushes the
// expected read value to a scoreboard queue when a read address is driven.
// The entry is popped and compared when num_edges appears one cycle later.
module tb_edge_tally;
   localparam int POPSIZE = 100;
   localparam int WINSIZE = 200;
   localparam int CW      = 9;
   localparam int SATMAX  = 511;

   logic          clk = 1'b0;
   logic          rst, edge_vld, win_end, rd_done;
   logic [7:0]    edge_src, edge_dst, rd_addr;
   logic          edge_rdy, data_rdy, err_oor;
   logic [CW-1:0] num_edges, edges_total;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int exp_q[$];
   int model_cnt[256];
   int model_win;

   always #5 clk = ~clk;

   edge_tally dut (
      .clk(clk), .rst(rst),
      .edge_vld(edge_vld), .edge_src(edge_src), .edge_dst(edge_dst),
      .edge_rdy(edge_rdy), .win_end(win_end), .data_rdy(data_rdy),
      .rd_addr(rd_addr), .num_edges(num_edges), .rd_done(rd_done),
      .edges_total(edges_total), .err_oor(err_oor)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 256; i++) model_cnt[i] = 0;
      model_win = 0;
   endtask

   task automatic model_edge(input int s, input int d);
      if (s < POPSIZE) model_cnt[s] = (model_cnt[s] + 1 > SATMAX) ? SATMAX : model_cnt[s] + 1;
      if (d < POPSIZE) model_cnt[d] = (model_cnt[d] + 1 > SATMAX) ? SATMAX : model_cnt[d] + 1;
      model_win++;
   endtask

   // Offer one edge for one cycle; the model counts it only if it is taken.
   task automatic drive_edge(input int s, input int d);
      edge_vld = 1'b1;
      edge_src = 8'(s);
      edge_dst = 8'(d);
      if (edge_rdy) model_edge(s, d);
      tick();
      edge_vld = 1'b0;
   endtask

   task automatic pulse_win_end();
      win_end = 1'b1;
      tick();
      win_end = 1'b0;
   endtask

   // Drive a read address and queue the model's answer for it.
   task automatic read_issue(input int id);
      rd_addr = 8'(id);
      exp_q.push_back((id < POPSIZE) ? model_cnt[id] : 0);
      tick();
   endtask

   task automatic release_window();
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
      tick();
      model_clear();
   endtask

   task automatic test_reset();
      rst = 1'b1; edge_vld = 1'b0; win_end = 1'b0; rd_done = 1'b0;
      edge_src = 8'd0; edge_dst = 8'd0; rd_addr = 8'd0;
      model_clear();
      tick(); tick();
      total_cnt++; if (edge_rdy !== 1'b1) $display("FAIL reset_edge_rdy: got %0b expected 1", edge_rdy); else pass_cnt++;
      total_cnt++; if (data_rdy !== 1'b0) $display("FAIL reset_data_rdy: got %0b expected 0", data_rdy); else pass_cnt++;
      total_cnt++; if (num_edges !== 9'd0) $display("FAIL reset_num_edges: got %0d expected 0", num_edges); else pass_cnt++;
      total_cnt++; if (edges_total !== 9'd0) $display("FAIL reset_edges_total: got %0d expected 0", edges_total); else pass_cnt++;
      total_cnt++; if (err_oor !== 1'b0) $display("FAIL reset_err_oor: got %0b expected 0", err_oor); else pass_cnt++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_and_clear();
      int ids[5];
      int got, exp;
      ids = '{1, 2, 3, 0, 150};
      drive_edge(1, 2);
      drive_edge(2, 3);
      drive_edge(2, 2);
      pulse_win_end();
      total_cnt++; if (data_rdy !== 1'b1) $display("FAIL basic_data_rdy: got %0b expected 1", data_rdy); else pass_cnt++;
      total_cnt++; if (edge_rdy !== 1'b0) $display("FAIL basic_edge_rdy: got %0b expected 0", edge_rdy); else pass_cnt++;
      total_cnt++; if (int'(edges_total) !== model_win) $display("FAIL basic_edges_total: got %0d expected %0d", edges_total, model_win); else pass_cnt++;
      for (int k = 0; k < 5; k++) begin
         read_issue(ids[k]);
         got = int'(num_edges); exp = exp_q.pop_front();
         total_cnt++; if (got !== exp) $display("FAIL basic_read_id%0d: got %0d expected %0d", ids[k], got, exp); else pass_cnt++;
      end
      // Offers while publishing must leave the table frozen.
      drive_edge(2, 2);
      pulse_win_end();
      read_issue(2);
      got = int'(num_edges); exp = exp_q.pop_front();
      total_cnt++; if (got !== exp) $display("FAIL frozen_read_id2: got %0d expected %0d", got, exp); else pass_cnt++;
      total_cnt++; if (int'(edges_total) !== 3) $display("FAIL frozen_edges_total: got %0d expected 3", edges_total); else pass_cnt++;
      // rd_done: one CLEAR cycle, then collecting again with an empty table.
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
      total_cnt++; if (data_rdy !== 1'b0 || edge_rdy !== 1'b0) $display("FAIL clear_cycle_flags: got rdy=%0b data=%0b expected 0 0", edge_rdy, data_rdy); else pass_cnt++;
      win_end = 1'b1;
      tick();
      win_end = 1'b0;
      model_clear();
      total_cnt++; if (edge_rdy !== 1'b1 || data_rdy !== 1'b0) $display("FAIL after_clear_flags: got rdy=%0b data=%0b expected 1 0", edge_rdy, data_rdy); else pass_cnt++;
      total_cnt++; if (edges_total !== 9'd0) $display("FAIL after_clear_total: got %0d expected 0", edges_total); else pass_cnt++;
      for (int k = 0; k < 3; k++) begin
         read_issue(ids[k]);
         got = int'(num_edges); exp = exp_q.pop_front();
         total_cnt++; if (got !== exp) $display("FAIL after_clear_read_id%0d: got %0d expected %0d", ids[k], got, exp); else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      int acc, got, exp;
      acc = 0;
      edge_vld = 1'b1; edge_src = 8'd0; edge_dst = 8'd1;
      for (int k = 0; k < WINSIZE; k++) begin
         if (edge_rdy) begin model_edge(0, 1); acc++; end
         tick();
      end
      total_cnt++; if (acc !== WINSIZE) $display("FAIL b2b_accepted: got %0d expected %0d", acc, WINSIZE); else pass_cnt++;
      total_cnt++; if (edge_rdy !== 1'b0 || data_rdy !== 1'b1) $display("FAIL b2b_full_flags: got rdy=%0b data=%0b expected 0 1", edge_rdy, data_rdy); else pass_cnt++;
      tick();
      edge_vld = 1'b0;
      total_cnt++; if (int'(edges_total) !== WINSIZE) $display("FAIL b2b_edges_total: got %0d expected %0d", edges_total, WINSIZE); else pass_cnt++;
      for (int k = 0; k < 2; k++) begin
         read_issue(k);
         got = int'(num_edges); exp = exp_q.pop_front();
         total_cnt++; if (got !== exp) $display("FAIL b2b_read_id%0d: got %0d expected %0d", k, got, exp); else pass_cnt++;
      end
      release_window();
   endtask

   task automatic test_oor();
      int got, exp;
      drive_edge(5, 150);
      pulse_win_end();
      total_cnt++; if (err_oor !== 1'b1) $display("FAIL oor_flag: got %0b expected 1", err_oor); else pass_cnt++;
      total_cnt++; if (int'(edges_total) !== model_win) $display("FAIL oor_edges_total: got %0d expected %0d", edges_total, model_win); else pass_cnt++;
      read_issue(5);
      got = int'(num_edges); exp = exp_q.pop_front();
      total_cnt++; if (got !== exp) $display("FAIL oor_read_id5: got %0d expected %0d", got, exp); else pass_cnt++;
      read_issue(150);
      got = int'(num_edges); exp = exp_q.pop_front();
      total_cnt++; if (got !== exp) $display("FAIL oor_read_id150: got %0d expected %0d", got, exp); else pass_cnt++;
      release_window();
      drive_edge(1, 1);
      pulse_win_end();
      total_cnt++; if (err_oor !== 1'b1) $display("FAIL oor_sticky: got %0b expected 1", err_oor); else pass_cnt++;
      read_issue(1);
      got = int'(num_edges); exp = exp_q.pop_front();
      total_cnt++; if (got !== exp) $display("FAIL selfloop_read_id1: got %0d expected %0d", got, exp); else pass_cnt++;
      release_window();
   endtask

   task automatic test_win_end_coincident();
      int got, exp;
      win_end = 1'b1;
      drive_edge(7, 8);
      win_end = 1'b0;
      total_cnt++; if (data_rdy !== 1'b1) $display("FAIL coinc_data_rdy: got %0b expected 1", data_rdy); else pass_cnt++;
      total_cnt++; if (int'(edges_total) !== model_win) $display("FAIL coinc_edges_total: got %0d expected %0d", edges_total, model_win); else pass_cnt++;
      read_issue(8);
      got = int'(num_edges); exp = exp_q.pop_front();
      total_cnt++; if (got !== exp) $display("FAIL coinc_read_id8: got %0d expected %0d", got, exp); else pass_cnt++;
      release_window();
      // rd_done while collecting is ignored; an empty window still publishes.
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
      total_cnt++; if (edge_rdy !== 1'b1) $display("FAIL rd_done_ignored: got %0b expected 1", edge_rdy); else pass_cnt++;
      pulse_win_end();
      total_cnt++; if (data_rdy !== 1'b1 || edges_total !== 9'd0) $display("FAIL empty_window: got data=%0b total=%0d expected 1 0", data_rdy, edges_total); else pass_cnt++;
      read_issue(7);
      got = int'(num_edges); exp = exp_q.pop_front();
      total_cnt++; if (got !== exp) $display("FAIL empty_read_id7: got %0d expected %0d", got, exp); else pass_cnt++;
      release_window();
   endtask

   task automatic test_reset_mid();
      int got, exp;
      // Raise the sticky flag so the reset has something to clear.
      drive_edge(200, 3);
      edge_vld = 1'b1;
      for (int k = 0; k < 49; k++) begin
         edge_src = 8'(k % 10); edge_dst = 8'((k + 3) % 10);
         tick();
      end
      edge_vld = 1'b0;
      rst = 1'b1;
      #1;
      total_cnt++; if (edge_rdy !== 1'b1 || data_rdy !== 1'b0 || err_oor !== 1'b0) $display("FAIL midrst_flags: got rdy=%0b data=%0b oor=%0b expected 1 0 0", edge_rdy, data_rdy, err_oor); else pass_cnt++;
      total_cnt++; if (edges_total !== 9'd0 || num_edges !== 9'd0) $display("FAIL midrst_values: got total=%0d num=%0d expected 0 0", edges_total, num_edges); else pass_cnt++;
      tick();
      rst = 1'b0;
      model_clear();
      tick();
      drive_edge(4, 4);
      pulse_win_end();
      total_cnt++; if (int'(edges_total) !== model_win) $display("FAIL fresh_edges_total: got %0d expected %0d", edges_total, model_win); else pass_cnt++;
      read_issue(4);
      got = int'(num_edges); exp = exp_q.pop_front();
      total_cnt++; if (got !== exp) $display("FAIL fresh_read_id4: got %0d expected %0d", got, exp); else pass_cnt++;
      read_issue(3);
      got = int'(num_edges); exp = exp_q.pop_front();
      total_cnt++; if (got !== exp) $display("FAIL fresh_read_id3: got %0d expected %0d", got, exp); else pass_cnt++;
      // Reset during publish drops back to collecting.
      rst = 1'b1;
      #1;
      total_cnt++; if (data_rdy !== 1'b0 || edge_rdy !== 1'b1) $display("FAIL pubrst_flags: got data=%0b rdy=%0b expected 0 1", data_rdy, edge_rdy); else pass_cnt++;
      tick();
      rst = 1'b0;
      model_clear();
      tick();
   endtask

   initial begin
      test_reset();
      test_basic_and_clear();
      test_back_to_back();
      test_oor();
      test_win_end_coincident();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/edge_tally.md
EDGE_TALLY -- requirements
Module: edge_tally

Interface
REQ-001 Parameter POPSIZE, default 100, number of population nodes (valid node IDs 0..POPSIZE-1).
REQ-002 Parameter WINSIZE, default 200, maximum accepted edges per window; CW = $clog2(WINSIZE)+1 is the count width.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 edge_vld  input  1  edge offer valid.
REQ-006 edge_src  input  8  source node ID of the offered edge.
REQ-007 edge_dst  input  8  destination node ID of the offered edge.
REQ-008 edge_rdy  output  1  block can accept an edge this cycle.
REQ-009 win_end  input  1  single-cycle pulse that closes the window early.
REQ-010 data_rdy  output  1  window closed; per-node degree table is stable and readable.
REQ-011 rd_addr  input  8  node ID for a table read, driven by the distribution reader.
REQ-012 num_edges  output  CW  registered degree of node rd_addr.
REQ-013 rd_done  input  1  single-cycle pulse: reader finished; release the table.
REQ-014 edges_total  output  CW  accepted edge count of the closed window.
REQ-015 err_oor  output  1  sticky flag: an accepted edge had an endpoint >= POPSIZE.

Function
REQ-016 States: COLLECT, PUBLISH, CLEAR; reset enters COLLECT.
REQ-017 edge_rdy SHALL be 1 only in COLLECT; an edge is accepted on a cycle with edge_vld && edge_rdy.
REQ-018 Accepted edge: cnt[src] and cnt[dst] each incremented by 1 in that same cycle; src == dst increments that node by 2.
REQ-019 Endpoint >= POPSIZE: that endpoint not counted, other endpoint still counted, err_oor set to 1, edge still counted toward the window.
REQ-020 Per-node counts saturate at 2**CW-1; no wrap-around.
REQ-021 Window edge counter increments per accepted edge; the accept that brings it to WINSIZE moves the FSM to PUBLISH on the next cycle.
REQ-022 win_end in COLLECT moves the FSM to PUBLISH on the next cycle; an edge accepted in the same cycle is counted first.
REQ-023 win_end with zero accepted edges still enters PUBLISH; the table is all zeros and edges_total = 0.
REQ-024 win_end outside COLLECT is ignored.
REQ-025 In PUBLISH: data_rdy = 1, edge_rdy = 0, and the table is frozen.
REQ-026 edges_total = final window edge count, held stable through PUBLISH.
REQ-027 num_edges = cnt[rd_addr] registered with 1-cycle latency in every state; rd_addr >= POPSIZE returns 0.
REQ-028 rd_done in PUBLISH moves the FSM to CLEAR; rd_done in other states is ignored.
REQ-029 CLEAR lasts exactly 1 cycle: all counts, the window counter and edges_total go to 0, data_rdy = 0, then COLLECT.
REQ-030 err_oor is cleared only by reset.

Reset
REQ-031 While rst = 1: all counts 0, window counter 0, state COLLECT, edge_rdy 1, data_rdy 0, num_edges 0, edges_total 0, err_oor 0.
REQ-032 Reset asserted mid-window or mid-PUBLISH discards the window; the first edge after deassertion is accepted normally.

Verification
REQ-033 Edges (1,2), (2,3), (2,2), then win_end -> data_rdy 1 next cycle; num_edges for IDs 1/2/3 = 1/4/1; edges_total = 3.
REQ-034 200 edges (0,1) streamed back-to-back -> edge_rdy drops after the 200th accept; cnt[0] = cnt[1] = 200; edges_total = 200.
REQ-035 Edge (5,150) -> cnt[5] = 1; err_oor = 1 and stays 1 after rd_done and a new window.
REQ-036 In PUBLISH, pulse rd_done -> one CLEAR cycle; then edge_rdy 1, data_rdy 0, num_edges for any ID = 0.
REQ-037 win_end coincident with an accepted edge (7,8) -> edge counted, edges_total includes it; win_end with no edges -> edges_total 0.
REQ-038 rst asserted after 50 edges -> all outputs return to reset values; a fresh window counts from 0.
